// File: rtl/debounce_fsm.sv
// Push-button debouncer: two-flop synchroniser followed by a four-state
// qualifier that only lets the output follow a level held STABLE_CYCLES samples.
module debounce_fsm #(
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       INC_raw,
   output logic       INC_db_out,
   output logic       INC_busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= INC_raw;
         sync2 <= sync1;
      end
   end

   // A contrary sample in a WAIT state wins over completion, so the
   // stable level is never declared on the same edge a bounce arrives.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_LOW: begin
            if (sync2) begin
               state_n = ST_WAIT_HIGH;
               cnt_n   = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (!sync2) begin
               state_n = ST_LOW;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_HIGH;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_HIGH: begin
            if (!sync2) begin
               state_n = ST_WAIT_LOW;
               cnt_n   = '0;
            end
         end
         ST_WAIT_LOW: begin
            if (sync2) begin
               state_n = ST_HIGH;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_LOW;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_LOW;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are flops loaded from the next-state decode, so they track
   // the state register exactly and cannot glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_LOW;
         cnt        <= '0;
         INC_db_out <= 1'b0;
         INC_busy   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         INC_db_out <= (state_n == ST_HIGH) || (state_n == ST_WAIT_LOW);
         INC_busy   <= (state_n == ST_WAIT_HIGH) || (state_n == ST_WAIT_LOW);
      end
   end

   assign state_dbg = state;

endmodule
